// File: rtl/gpio_in_conditioner_pkg.sv
// gpio_cond_pkg: shared widths, default parameters and helpers for the GPIO input
// conditioning slice (debounce bit, conditioner top and its bus interface).
package gpio_cond_pkg;

  localparam int unsigned GPIO_W          = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEB_CYCLES  = 4;

  // Stability counter width for a given debounce length (holds 0..deb).
  function automatic int unsigned cnt_width(input int unsigned deb);
    return $clog2(deb + 1);
  endfunction

endpackage : gpio_cond_pkg

// File: rtl/gpio_in_conditioner_if.sv
// gpio_cond_if: pad/config/status bundle of the GPIO input conditioner.
//   master : drives pad_in, rise_en, fall_en, irq_mask, irq_clr; observes results
//   slave  : the conditioner; drives gpio_in, edge_rise, edge_fall, irq_status, irq
interface gpio_cond_if
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_W
) ();

  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] edge_rise;
  logic [WIDTH-1:0] edge_fall;
  logic [WIDTH-1:0] irq_status;
  logic             irq;

  modport master (
    output pad_in, rise_en, fall_en, irq_mask, irq_clr,
    input  gpio_in, edge_rise, edge_fall, irq_status, irq
  );

  modport slave (
    input  pad_in, rise_en, fall_en, irq_mask, irq_clr,
    output gpio_in, edge_rise, edge_fall, irq_status, irq
  );

endinterface : gpio_cond_if

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// gpio_debounce_bit: one GPIO line -- synchroniser chain, stability counter and the
// accepted (debounced) level flop.
//   clk, rst : clock, async active-high reset
//   pad      : raw asynchronous pad level
//   level    : debounced level (registered)
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES, // 2..3
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES   // 1..255
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level
);

  localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s_c;

  // Metastability chain; only the last stage is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  assign s_c = sync_q[SYNC_STAGES-1];

  // Count consecutive cycles the synchronised value disagrees with the accepted
  // level; any agreement restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (s_c == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      level <= s_c;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule : gpio_debounce_bit

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: conditions raw pad inputs for the AHB GPIO GPIOIN port.
// Each line is synchronised and debounced independently; debounced edges are
// reported as pulses and as sticky, maskable interrupt status.
//   clk, rst         : clock, async active-high reset
//   bus.pad_in       : raw asynchronous pad levels
//   bus.rise_en/fall_en : per-bit edge enables into irq_status
//   bus.irq_mask     : per-bit mask onto irq (1 = enabled)
//   bus.irq_clr      : write-one-to-clear pulse for irq_status
//   bus.gpio_in      : debounced level
//   bus.edge_rise/edge_fall : 1-cycle pulses on debounced edges
//   bus.irq_status   : sticky edge status
//   bus.irq          : |(irq_status & irq_mask), registered
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = GPIO_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  gpio_cond_if.slave  bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] set_c;
  logic             irq_q;

  // One independent debouncer per line.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .pad   (bus.pad_in[i]),
      .level (level[i])
    );
  end

  // Edge detect against the previous debounced level; pulses land one cycle
  // after the level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level;
      rise_q  <= level & ~level_q;
      fall_q  <= ~level & level_q;
    end
  end

  assign set_c = (rise_q & bus.rise_en) | (fall_q & bus.fall_en);

  // Sticky status: set is OR'ed in after the clear so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~bus.irq_clr) | set_c;
      irq_q    <= |(status_q & bus.irq_mask);
    end
  end

  assign bus.gpio_in    = level;
  assign bus.edge_rise  = rise_q;
  assign bus.edge_fall  = fall_q;
  assign bus.irq_status = status_q;
  assign bus.irq        = irq_q;

endmodule : gpio_in_conditioner

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: a window-based reference model pushes
// the expected outputs of every clock; a monitor pops and compares them. Directed
// sequences add fixed-latency checks on top of randomized pad traffic.
module tb_gpio_in_conditioner;

  localparam int unsigned W    = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned NH   = SYNC + DEB;

  typedef struct packed {
    logic [W-1:0] gpio;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] st;
    logic         irq;
  } exp_t;

  logic clk;
  logic rst;
  gpio_cond_if #(.WIDTH(W)) bus ();

  gpio_in_conditioner #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ph[j] holds the pad value sampled j edges ago. A line takes
  // a new level once the last DEB values out of the synchroniser all agree on it.
  logic [W-1:0] ph [NH];
  logic [W-1:0] m_lvl, m_lvl_d, m_rise, m_fall, m_st;
  logic         m_irq;

  always @(posedge clk) begin : model
    logic [W-1:0] all1, all0, n_lvl, n_rise, n_fall, n_st;
    logic         n_irq;
    exp_t         e;
    if (rst) begin
      for (int j = 0; j < NH; j++) ph[j] <= '0;
      n_lvl = '0; n_rise = '0; n_fall = '0; n_st = '0; n_irq = 1'b0;
      m_lvl_d <= '0;
    end else begin
      all1 = '1;
      all0 = '1;
      for (int j = SYNC - 1; j < SYNC + DEB - 1; j++) begin
        all1 &= ph[j];
        all0 &= ~ph[j];
      end
      n_lvl  = (m_lvl | all1) & ~all0;
      n_rise = m_lvl & ~m_lvl_d;
      n_fall = ~m_lvl & m_lvl_d;
      n_st   = (m_st & ~bus.irq_clr) | (m_rise & bus.rise_en) | (m_fall & bus.fall_en);
      n_irq  = |(m_st & bus.irq_mask);
      ph[0] <= bus.pad_in;
      for (int j = 1; j < NH; j++) ph[j] <= ph[j-1];
      m_lvl_d <= m_lvl;
    end
    m_lvl  <= n_lvl;
    m_rise <= n_rise;
    m_fall <= n_fall;
    m_st   <= n_st;
    m_irq  <= n_irq;
    e.gpio = n_lvl; e.rise = n_rise; e.fall = n_fall; e.st = n_st; e.irq = n_irq;
    sb.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_empty: got no expected entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("gpio_in",    bus.gpio_in,    e.gpio);
      chk("edge_rise",  bus.edge_rise,  e.rise);
      chk("edge_fall",  bus.edge_fall,  e.fall);
      chk("irq_status", bus.irq_status, e.st);
      chk("irq",        W'(bus.irq),    W'(e.irq));
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  int rise_cnt;

  initial begin
    rst = 1'b1;
    bus.pad_in = '0; bus.rise_en = '0; bus.fall_en = '0;
    bus.irq_mask = '0; bus.irq_clr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Clean step on bit 0.
    bus.pad_in[0] = 1'b1;
    repeat (5) at_edge();
    chk("t1_gpio_before", W'(bus.gpio_in[0]), W'(0));
    at_edge();
    chk("t1_gpio_at6", W'(bus.gpio_in[0]), W'(1));
    chk("t1_rise_early", bus.edge_rise, W'(0));
    at_edge();
    chk("t1_rise_pulse", bus.edge_rise, W'(16'h0001));
    at_edge();
    chk("t1_rise_end", bus.edge_rise, W'(0));

    // Three-cycle glitch on bit 3.
    @(negedge clk);
    bus.pad_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    bus.pad_in[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_edge();
      chk("t2_gpio3", W'(bus.gpio_in[3]), W'(0));
      chk("t2_rise3", W'(bus.edge_rise[3]), W'(0));
    end

    // Bounce 1,0,1 on bit 5, then held.
    @(negedge clk);
    bus.pad_in[5] = 1'b1;
    @(negedge clk);
    bus.pad_in[5] = 1'b0;
    @(negedge clk);
    bus.pad_in[5] = 1'b1;
    rise_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      at_edge();
      if (bus.edge_rise[5]) rise_cnt++;
      if (i == 5) chk("t3_gpio5_before", W'(bus.gpio_in[5]), W'(0));
      if (i == 6) chk("t3_gpio5_at6", W'(bus.gpio_in[5]), W'(1));
    end
    chk("t3_rise_count", W'(rise_cnt), W'(1));

    // Status and irq, masked in.
    @(negedge clk);
    bus.pad_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus.rise_en = W'(16'h0001);
    bus.irq_mask = W'(16'h0001);
    bus.pad_in[0] = 1'b1;
    repeat (8) at_edge();
    chk("t4_status_set", bus.irq_status, W'(16'h0001));
    chk("t4_irq_lag", W'(bus.irq), W'(0));
    at_edge();
    chk("t4_irq_set", W'(bus.irq), W'(1));
    @(negedge clk);
    bus.irq_clr = W'(16'h0001);
    at_edge();
    chk("t4_status_clr", bus.irq_status, W'(0));
    chk("t4_irq_hold", W'(bus.irq), W'(1));
    @(negedge clk);
    bus.irq_clr = '0;
    at_edge();
    chk("t4_irq_clr", W'(bus.irq), W'(0));

    // Same, masked out.
    @(negedge clk);
    bus.pad_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus.irq_mask = '0;
    bus.pad_in[0] = 1'b1;
    repeat (8) at_edge();
    chk("t4m_status_set", bus.irq_status, W'(16'h0001));
    repeat (2) begin
      at_edge();
      chk("t4m_irq_off", W'(bus.irq), W'(0));
    end

    // Set/clear collision on bit 0.
    @(negedge clk);
    bus.pad_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus.pad_in[0] = 1'b1;
    repeat (7) at_edge();
    chk("t5_rise", bus.edge_rise, W'(16'h0001));
    @(negedge clk);
    bus.irq_clr = W'(16'h0001);
    at_edge();
    chk("t5_set_wins", W'(bus.irq_status[0]), W'(1));
    at_edge();
    chk("t5_clr_after", W'(bus.irq_status[0]), W'(0));
    @(negedge clk);
    bus.irq_clr = '0;

    // Randomized traffic, including one reset pulse.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.pad_in = bus.pad_in ^ W'($urandom & $urandom & $urandom);
      if ($urandom_range(15, 0) == 0) begin
        bus.rise_en  = W'($urandom);
        bus.fall_en  = W'($urandom);
        bus.irq_mask = W'($urandom);
      end
      bus.irq_clr = W'($urandom & $urandom & $urandom & $urandom);
      rst = (c >= 700 && c < 702);
    end

    // Reset mid-debounce with all pads high.
    @(negedge clk);
    bus.pad_in = '0;
    bus.irq_clr = '0;
    repeat (12) @(negedge clk);
    bus.pad_in = '1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_gpio", bus.gpio_in, W'(0));
    chk("t6_rst_rise", bus.edge_rise, W'(0));
    chk("t6_rst_fall", bus.edge_fall, W'(0));
    chk("t6_rst_status", bus.irq_status, W'(0));
    chk("t6_rst_irq", W'(bus.irq), W'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) at_edge();
    chk("t6_gpio_before", bus.gpio_in, W'(0));
    at_edge();
    chk("t6_gpio_at6", bus.gpio_in, W'(16'hFFFF));
    at_edge();
    chk("t6_rise_pulse", bus.edge_rise, W'(16'hFFFF));
    at_edge();
    chk("t6_rise_end", bus.edge_rise, W'(0));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_gpio_in_conditioner
